// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared sizes and sample/frame types for the fft8 input framer
package fft8_pkg;
  localparam int FFT_N  = 8;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] sample_t;
  typedef sample_t [FFT_N-1:0] frame_t;
endpackage

// File: rtl/fft8_frame_bank.sv
// rtl/fft8_frame_bank.sv - one 8-entry frame register bank with indexed write and tail zero-fill
module fft8_frame_bank
  import fft8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill_en,
  input  logic [IDX_W:0]    fill_idx,
  output frame_t            mem
);

  frame_t mem_q, mem_d;

  // The write lands first; the fill index already points past it when both fire.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
    if (fill_en) begin
      for (int i = 0; i < FFT_N; i++) begin
        if ((IDX_W+1)'(i) >= fill_idx) begin
          mem_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign mem = mem_q;

endmodule

// File: rtl/fft8_input_framer.sv
// rtl/fft8_input_framer.sv - packs serial samples into ping-pong 8-sample frames; flush via FFT8_FRAMER_FLUSH_EN
module fft8_input_framer
  import fft8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
`ifdef FFT8_FRAMER_FLUSH_EN
  input  logic              flush,
`endif
  output logic [DATA_W-1:0] A0,
  output logic [DATA_W-1:0] A1,
  output logic [DATA_W-1:0] A2,
  output logic [DATA_W-1:0] A3,
  output logic [DATA_W-1:0] A4,
  output logic [DATA_W-1:0] A5,
  output logic [DATA_W-1:0] A6,
  output logic [DATA_W-1:0] A7,
  output logic              frame_valid,
  input  logic              frame_ready
);

  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;

  logic             accept, do_flush, complete, rel_fire;
  logic [IDX_W:0]   fill_cnt;
  frame_t           bank_mem [2];
  frame_t           rd_frame;

  assign in_ready    = !full_q[wr_sel_q];
  assign frame_valid = full_q[rd_sel_q];
  assign accept      = in_valid && in_ready;
  assign rel_fire    = frame_valid && frame_ready;
  assign fill_cnt    = (IDX_W+1)'(wr_cnt_q) + (IDX_W+1)'(accept);

`ifdef FFT8_FRAMER_FLUSH_EN
  assign do_flush = flush && in_ready && (fill_cnt != '0);
`else
  assign do_flush = 1'b0;
`endif

  assign complete = (accept && (wr_cnt_q == IDX_W'(FFT_N-1))) || do_flush;

  // Completion targets the non-full write bank, release the full read bank, so both may apply.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = accept ? wr_cnt_q + 1'b1 : wr_cnt_q;
    if (complete) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
      wr_cnt_d         = '0;
    end
    if (rel_fire) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft8_frame_bank u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (accept && (wr_sel_q == 1'(b))),
      .wr_idx   (wr_cnt_q),
      .wr_data  (in_data),
      .fill_en  (do_flush && (wr_sel_q == 1'(b))),
      .fill_idx (fill_cnt),
      .mem      (bank_mem[b])
    );
  end

  assign rd_frame = rd_sel_q ? bank_mem[1] : bank_mem[0];
  assign A0 = rd_frame[0];
  assign A1 = rd_frame[1];
  assign A2 = rd_frame[2];
  assign A3 = rd_frame[3];
  assign A4 = rd_frame[4];
  assign A5 = rd_frame[5];
  assign A6 = rd_frame[6];
  assign A7 = rd_frame[7];

endmodule

// File: tb/tb_fft8_input_framer.sv
// tb/tb_fft8_input_framer.sv - randomized self-checking bench for fft8_input_framer against a frame-queue model
module tb_fft8_input_framer;

  typedef logic [31:0] frm_t [8];

`ifdef FFT8_FRAMER_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, frame_valid, frame_ready, flush_drv;
  logic [31:0] in_data;
  logic [31:0] A0, A1, A2, A3, A4, A5, A6, A7;
  logic [31:0] a_act [8];

  int total = 0;
  int bad   = 0;

  frm_t        mq[$];
  logic [31:0] part[$];

  always #5 clk = ~clk;

  fft8_input_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
`ifdef FFT8_FRAMER_FLUSH_EN
    .flush       (flush_drv),
`endif
    .A0          (A0),
    .A1          (A1),
    .A2          (A2),
    .A3          (A3),
    .A4          (A4),
    .A5          (A5),
    .A6          (A6),
    .A7          (A7),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  always_comb begin
    a_act[0] = A0; a_act[1] = A1; a_act[2] = A2; a_act[3] = A3;
    a_act[4] = A4; a_act[5] = A5; a_act[6] = A6; a_act[7] = A7;
  end

  // One clock: drive inputs, take the edge, advance the frame-queue model.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    int   n;
    bit   acc;
    frm_t t;
    in_valid    = v;
    in_data     = d;
    frame_ready = r;
    flush_drv   = f;
    @(posedge clk);
    n   = mq.size();
    acc = v && (n < 2);
    if (n > 0 && r) void'(mq.pop_front());
    if (acc) part.push_back(d);
    if (FLUSH_ON && flush_drv && n < 2 && part.size() > 0)
      while (part.size() < 8) part.push_back(32'd0);
    if (part.size() == 8) begin
      for (int i = 0; i < 8; i++) t[i] = part[i];
      mq.push_back(t);
      part.delete();
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    in_data     = $urandom;
    frame_ready = 1'b0;
    flush_drv   = 1'b0;
    @(posedge clk);
    mq.delete();
    part.delete();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_flags k=%0d frame_valid=%0b in_ready=%0b exp 0/1", k, frame_valid, in_ready);
      end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (a_act[i] !== 32'd0) begin
          bad++;
          $display("FAIL reset_A%0d k=%0d got=%0h exp=0", i, k, a_act[i]);
        end
      end
      step(1'b0, 32'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_basic();
    logic [31:0] vals [8];
    vals = '{30, 20, 10, 0, 0, 10, 20, 30};
    pulse_reset();
    for (int s = 0; s < 8; s++) begin
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL basic_in_ready s=%0d got=%0b exp=1", s, in_ready);
      end
      step(1'b1, vals[s], 1'b0, 1'b0);
      total++;
      if (frame_valid !== (s == 7)) begin
        bad++;
        $display("FAIL basic_frame_valid s=%0d got=%0b exp=%0b", s, frame_valid, s == 7);
      end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_act[i] !== vals[i]) begin
        bad++;
        $display("FAIL basic_A%0d got=%0d exp=%0d", i, a_act[i], vals[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    logic pre;
    pulse_reset();
    for (int c = 0; c < 40 && sent < 16; c++) begin
      pre = in_ready;
      step(1'b1, sent + 1, 1'b0, 1'b0);
      if (pre) sent++;
    end
    for (int c = 0; c < 3; c++) begin
      total++;
      if (in_ready !== 1'b0 || frame_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_stall c=%0d in_ready=%0b frame_valid=%0b exp 0/1", c, in_ready, frame_valid);
      end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (a_act[i] !== 32'(i + 1)) begin
          bad++;
          $display("FAIL bp_first_A%0d got=%0d exp=%0d", i, a_act[i], i + 1);
        end
      end
      step(1'b1, 32'd17, 1'b0, 1'b0);
    end
    step(1'b1, 32'd17, 1'b1, 1'b0);
    total++;
    if (in_ready !== 1'b1 || frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_release in_ready=%0b frame_valid=%0b exp 1/1", in_ready, frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_act[i] !== 32'(i + 9)) begin
        bad++;
        $display("FAIL bp_second_A%0d got=%0d exp=%0d", i, a_act[i], i + 9);
      end
    end
    for (int v = 17; v <= 20; v++) step(1'b1, v, 1'b0, 1'b0);
    total++;
    if (part.size() != 4 || frame_valid !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_tail held=%0d frame_valid=%0b in_ready=%0b exp 4/1/1", part.size(), frame_valid, in_ready);
    end
  endtask

  task automatic test_sustained();
    int rel = 0;
    pulse_reset();
    for (int s = 0; s < 67; s++) begin
      if (frame_valid === 1'b1) begin
        total++;
        if (A0 !== 32'(rel * 8)) begin
          bad++;
          $display("FAIL sustain_A0 frame=%0d got=%0d exp=%0d", rel, A0, rel * 8);
        end
        rel++;
      end
      if (s < 64) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL sustain_in_ready s=%0d got=%0b exp=1", s, in_ready);
        end
      end
      step(s < 64, s, 1'b1, 1'b0);
    end
    total++;
    if (rel != 8) begin
      bad++;
      $display("FAIL sustain_count got=%0d exp=8", rel);
    end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    for (int s = 0; s < 5; s++) step(1'b1, 32'd90 + s, 1'b0, 1'b0);
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (frame_valid !== 1'b0 || {A0, A3, A7} !== 96'd0) begin
        bad++;
        $display("FAIL midrst_clear k=%0d frame_valid=%0b A0=%0h A3=%0h A7=%0h exp 0", k, frame_valid, A0, A3, A7);
      end
      if (k == 0) step(1'b0, 32'd0, 1'b0, 1'b0);
    end
    for (int s = 0; s < 8; s++) step(1'b1, 32'd7, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_valid got=%0b exp=1", frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_act[i] !== 32'd7) begin
        bad++;
        $display("FAIL midrst_A%0d got=%0d exp=7", i, a_act[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    for (int s = 0; s < 8; s++) step(1'b1, 32'd100 + s, 1'b0, 1'b0);
    for (int s = 0; s < 7; s++) step(1'b1, 32'd200 + s, 1'b0, 1'b0);
    total++;
    if (dut.full_q !== 2'b01) begin
      bad++;
      $display("FAIL simul_pre_full got=%b exp=01", dut.full_q);
    end
    step(1'b1, 32'd207, 1'b1, 1'b0);
    total++;
    if (frame_valid !== 1'b1 || dut.full_q !== 2'b10) begin
      bad++;
      $display("FAIL simul_post frame_valid=%0b full=%b exp 1/10", frame_valid, dut.full_q);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_act[i] !== 32'(200 + i)) begin
        bad++;
        $display("FAIL simul_A%0d got=%0d exp=%0d", i, a_act[i], 200 + i);
      end
    end
  endtask

`ifdef FFT8_FRAMER_FLUSH_EN
  task automatic test_flush();
    logic [31:0] exp_f [8];
    exp_f = '{5, 6, 7, 8, 0, 0, 0, 0};
    pulse_reset();
    for (int v = 5; v <= 7; v++) step(1'b1, v, 1'b0, 1'b0);
    step(1'b1, 32'd8, 1'b0, 1'b1);
    total++;
    if (frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL flush_valid got=%0b exp=1", frame_valid);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_act[i] !== exp_f[i]) begin
        bad++;
        $display("FAIL flush_A%0d got=%0d exp=%0d", i, a_act[i], exp_f[i]);
      end
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    total++;
    if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_empty frame_valid=%0b in_ready=%0b exp 0/1", frame_valid, in_ready);
    end
  endtask
`endif

  task automatic test_random();
    int errs;
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 11) == 0);
      errs = 0;
      if (in_ready !== (mq.size() < 2)) errs++;
      if (frame_valid !== (mq.size() > 0)) errs++;
      if (mq.size() > 0)
        for (int i = 0; i < 8; i++) if (a_act[i] !== mq[0][i]) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL random c=%0d in_ready=%0b frame_valid=%0b A0=%0h exp_frames=%0d errs=%0d",
                 c, in_ready, frame_valid, A0, mq.size(), errs);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    frame_ready = 1'b0;
    flush_drv   = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_sustained();
    test_mid_reset();
    test_simultaneous();
`ifdef FFT8_FRAMER_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft8_input_framer.md
# fft8_input_framer

Upstream feeder for the 8-point `fft8` core. It accepts a serial stream of 32-bit real samples with a valid/ready handshake and packs each group of 8 consecutive samples into a frame. It presents each frame in parallel on `A0..A7` with a frame-level valid/ready handshake. Two ping-pong frame banks let one frame be held for the FFT consumer while the next one fills.

## Interface
- `DATA_W`, 32, sample width. It matches the fft8 input width. The frame length is fixed at 8.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_data`  in  DATA_W  input sample, time order.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  framer can accept a sample this cycle.
- `flush`  in  1  zero-pad and close the partial frame. Present only with `FFT8_FRAMER_FLUSH_EN`.
- `A0..A7`  out  DATA_W each  frame samples. `A0` is the oldest sample and maps directly onto the fft8 inputs.
- `frame_valid`  out  1  `A0..A7` hold a complete frame.
- `frame_ready`  in  1  consumer has captured the current frame, i.e. the fft8 results.

## Operation
- State:
  - two banks of 8×DATA_W
  - `full[1:0]`
  - `wr_sel`, `rd_sel` (1 bit each)
  - `wr_cnt` (3 bits)
- Combinational outputs:
  - `in_ready = !full[wr_sel]`
  - `frame_valid = full[rd_sel]`
  - `A0..A7 = bank[rd_sel][0..7]`
- A sample is accepted when `in_valid && in_ready`:
  - `bank[wr_sel][wr_cnt] <= in_data`, and `wr_cnt` increments.
  - When `wr_cnt == 7`: `full[wr_sel] <= 1`, `wr_sel` toggles and `wr_cnt <= 0`. The counter wraps 7→0 only on frame completion.
- A frame is released when `frame_valid && frame_ready`: `full[rd_sel] <= 0` and `rd_sel` toggles. Bank contents are not cleared on release.
- Completion and release in the same cycle always target different banks. Both updates apply.
- Both banks full: `in_ready = 0`. Incoming samples are back-pressured, never dropped or overwritten.
- `frame_ready` while `frame_valid = 0` is ignored.
- `in_data` is not interpreted. Signedness belongs to the fft8 core.

## Timing
- Reset values (applied at the first rising edge with `rst_n = 0`, including mid-frame):
  - `full = 0`, `wr_sel = rd_sel = 0`, `wr_cnt = 0`
  - banks cleared to 0, so `A0..A7 = 0`
  - `frame_valid = 0`, `in_ready = 1`
  - Any partial or pending frame is discarded.
- Latency: the 8th sample is accepted at edge k, and `frame_valid = 1` in the cycle after edge k. `A0..A7` are stable from then until release.
- Throughput:
  - Sustains 1 sample per cycle (no bubbles) if each frame is released within 8 cycles of becoming valid.
  - Otherwise `in_ready` drops for exactly the cycles in which both banks are full.
- `in_ready` has no combinational dependency on `in_valid`.
- `frame_valid` has no combinational dependency on `frame_ready`.

## Configuration
- `FFT8_FRAMER_FLUSH_EN` defined:
  - The `flush` port exists. `flush` is acted on only in a cycle where `in_ready = 1`.
  - If the resulting fill count is greater than 0, the slots from the fill position up to index 7 are written with 0. The bank is then marked full, `wr_sel` toggles and `wr_cnt <= 0`, all at one edge.
  - `flush` together with an accepted sample: the sample is written first, then the remaining slots are zero-padded.
  - `flush` with `wr_cnt = 0` and no sample accepted: no effect.
  - `flush` while `in_ready = 0`: ignored, and the caller holds it.
- `FFT8_FRAMER_FLUSH_EN` undefined: no `flush` port. A partial frame stays pending until it completes or reset.

## Structure
- Package `fft8_pkg` holds:
  - `FFT_N = 8` and `IDX_W = 3`
  - the default `DATA_W`
  - `typedef` `sample_t` (DATA_W bits) and `frame_t` (array of 8 `sample_t`)
- Sub-module `fft8_frame_bank`:
  - one 8-entry register bank with synchronous clear on reset
  - indexed single write
  - zero-fill of slots ≥ index (flush)
  - instantiated twice
- The top level holds the pointers, `full` flags and handshake logic.

## Test plan
- **Basic frame:** reset, then stream 30,20,10,0,0,10,20,30 on consecutive cycles with `frame_ready = 0`.
  - `frame_valid` rises the cycle after the 8th sample.
  - `A0..A7 = 30,20,10,0,0,10,20,30`.
  - `in_ready` stays 1.
- **Back-pressure:** stream 20 samples (values 1..20) with `frame_ready = 0`.
  - After the 16th sample, `in_ready = 0`.
  - Samples 17..20 are held at the source.
  - Releasing one frame shows `A0..A7 = 9..16` and restores `in_ready`.
- **Sustained rate:** continuous `in_valid` and `frame_ready = 1` for 64 samples (values 0..63).
  - 8 frames are released in order: `A0` = 0,8,…,56.
  - `in_ready` never drops.
- **Reset mid-frame:** after 5 samples, pulse `rst_n = 0` for 1 cycle, then send 8 samples of 7.
  - The first released frame is all 7s.
  - Outputs read 0 and `frame_valid` is 0 during and immediately after reset.
- **Flush (macro on):** after samples 5,6,7, assert `flush` together with sample 8.
  - The next cycle shows `frame_valid = 1` with `A0..A7 = 5,6,7,8,0,0,0,0`.
  - `flush` with an empty fill (`wr_cnt = 0`) produces no frame.
- **Simultaneous complete and release:** bank 0 is full, and `frame_ready = 1` in the same cycle that the 8th sample of bank 1 is accepted.
  - The next cycle shows `frame_valid = 1` with bank 1 data.
  - `full = 2'b10`.
